// File: rtl/proc_run_ctrl_pkg.sv
// Shared types for the processor run sequencer: FSM state encoding and
// the status codes a harness uses to classify a finished run.
package proc_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DRAIN,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    STATUS_NONE    = 2'd0,
    STATUS_PASS    = 2'd1,
    STATUS_FAIL    = 2'd2,
    STATUS_TIMEOUT = 2'd3
  } status_t;

  // Collapses the three status flags into one code for logging harnesses.
  function automatic status_t status_code(input logic done, input logic pass,
                                          input logic timeout);
    if (!done)   return STATUS_NONE;
    if (timeout) return STATUS_TIMEOUT;
    if (pass)    return STATUS_PASS;
    return STATUS_FAIL;
  endfunction

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Bundle of harness-side controls, core-side feedback and run status for
// the run sequencer; slave is the sequencer, master is whoever drives it.
interface proc_run_ctrl_if #(
  parameter int PC_W   = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);

  logic              start;
  logic [PC_W-1:0]   startpc_in;
  logic [PC_W-1:0]   endpc;
  logic [DATA_W-1:0] expected;
  logic [CNT_W-1:0]  max_cycles;
  logic [PC_W-1:0]   currentpc;
  logic [DATA_W-1:0] dmemout;

  logic              cpu_resetl;
  logic [PC_W-1:0]   cpu_startpc;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [DATA_W-1:0] result;

  modport slave (
    input  start, startpc_in, endpc, expected, max_cycles, currentpc, dmemout,
    output cpu_resetl, cpu_startpc, busy, done, pass, timeout, cycle_count, result
  );

  modport master (
    output start, startpc_in, endpc, expected, max_cycles, currentpc, dmemout,
    input  cpu_resetl, cpu_startpc, busy, done, pass, timeout, cycle_count, result
  );

endinterface

// File: rtl/proc_run_ctrl.sv
// Run sequencer for the single-cycle core: holds it in reset, runs it from a
// latched start PC to a latched end PC, then grades the final dmemout.
module proc_run_ctrl
  import proc_run_pkg::*;
#(
  parameter int PC_W         = 64,
  parameter int DATA_W       = 64,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 1
) (
  input logic            CLK,
  input logic            resetl,
  proc_run_ctrl_if.slave bus
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t            state;
  state_t            state_nxt;

  logic [PC_W-1:0]   startpc_q;
  logic [PC_W-1:0]   endpc_q;
  logic [DATA_W-1:0] expected_q;
  logic [CNT_W-1:0]  max_q;

  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [RC_W-1:0]   rst_cnt;
  logic              pass_q;
  logic              timeout_q;
  logic [DATA_W-1:0] result_q;

  logic              start_ok;
  logic              end_hit;
  logic              wd_hit;
  logic              rst_done;

  // A start is only honoured once the previous run has fully finished.
  assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
  assign end_hit  = bus.currentpc >= endpc_q;
  assign cnt_inc  = cycle_q + CNT_W'(1);
  assign wd_hit   = (max_q != '0) && (cnt_inc == max_q);
  assign rst_done = rst_cnt == RC_W'(RESET_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_ok) state_nxt = RESET;
      RESET: if (rst_done) state_nxt = RUN;
      RUN: begin
        if (end_hit)     state_nxt = DRAIN;
        else if (wd_hit) state_nxt = DONE;
      end
      DRAIN: state_nxt = CHECK;
      CHECK: state_nxt = DONE;
      DONE:  if (start_ok) state_nxt = RESET;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs decode only the state register, never an input.
  always_comb begin
    bus.cpu_resetl = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    unique case (state)
      IDLE:  ;
      RESET: bus.busy = 1'b1;
      RUN, DRAIN, CHECK: begin
        bus.cpu_resetl = 1'b1;
        bus.busy       = 1'b1;
      end
      DONE: begin
        bus.cpu_resetl = 1'b1;
        bus.done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      startpc_q  <= '0;
      endpc_q    <= '0;
      expected_q <= '0;
      max_q      <= '0;
      cycle_q    <= '0;
      rst_cnt    <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      if (start_ok) begin
        startpc_q  <= bus.startpc_in;
        endpc_q    <= bus.endpc;
        expected_q <= bus.expected;
        max_q      <= bus.max_cycles;
        rst_cnt    <= '0;
        pass_q     <= 1'b0;
        timeout_q  <= 1'b0;
        result_q   <= '0;
      end
      unique case (state)
        RESET: begin
          rst_cnt <= rst_cnt + RC_W'(1);
          if (rst_done) cycle_q <= '0;
        end
        RUN: begin
          if (cycle_q != {CNT_W{1'b1}}) cycle_q <= cnt_inc;
          // Reaching the end PC outranks a watchdog expiring on the same cycle.
          if (!end_hit && wd_hit) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            result_q  <= '0;
          end
        end
        CHECK: begin
          result_q  <= bus.dmemout;
          pass_q    <= (bus.dmemout == expected_q);
          timeout_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_startpc = startpc_q;
  assign bus.cycle_count = cycle_q;
  assign bus.pass        = pass_q;
  assign bus.timeout     = timeout_q;
  assign bus.result      = result_q;

endmodule
